// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the 2-way, 8-set cache miss controller.
package cache_miss_ctrl_pkg;

    localparam int unsigned TAG_W_DEF   = 5;
    localparam int unsigned INDEX_W_DEF = 3;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned NUM_SETS    = 1 << INDEX_W_DEF;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StMissWait,
        StFill,
        StResp
    } state_e;

    // Fill an empty way first (way0 before way1); only consult FIFO order when the set is full.
    function automatic logic pick_victim(input logic valid0, input logic valid1,
                                         input logic repl_way);
        if (!valid0) begin
            return 1'b0;
        end else if (!valid1) begin
            return 1'b1;
        end
        return repl_way;
    endfunction

endpackage

// File: rtl/cache_way_store.sv
// One cache way: per-set valid bit, tag and line data; single write port, combinational read.
module cache_way_store
    import cache_miss_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data
);

    localparam int unsigned Sets = 1 << INDEX_W;

    logic [Sets-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [Sets];
    logic [DATA_W-1:0] data_q [Sets];

    // Valid bits are the only state that needs clearing; tag/data are qualified by them.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage, written on a fill.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: tag lookup over two ways, memory fetch on miss, victim fill and
// replacement-unit update strobe. All state advances on the falling clock edge.
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [TAG_W+INDEX_W-1:0] req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic                     resp_way,
    output logic [DATA_W-1:0]        resp_data,
    output logic [INDEX_W-1:0]       repl_index,
    input  logic                     repl_way,
    output logic                     repl_update,
    output logic                     mem_req_valid,
    output logic [TAG_W+INDEX_W-1:0] mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [DATA_W-1:0]        mem_resp_data
);

    localparam int unsigned ADDR_W = TAG_W + INDEX_W;

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    logic              victim_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;

    logic              valid0, valid1;
    logic [TAG_W-1:0]  tag0, tag1;
    logic [DATA_W-1:0] data0, data1;
    logic              hit0, hit1;
    logic              fill_en;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];

    assign hit0 = valid0 && (tag0 == tag);
    assign hit1 = valid1 && (tag1 == tag);

    // Response data is only sampled while waiting for it; anything earlier or later is dropped.
    assign fill_en = (state == StMissWait) && mem_resp_valid;

    assign repl_index   = (state == StIdle) ? '0 : idx;
    assign mem_req_addr = addr_q;

    cache_way_store #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .DATA_W  (DATA_W)
    ) u_way0 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fill_en && !victim_q),
        .wr_index (idx),
        .wr_tag   (tag),
        .wr_data  (mem_resp_data),
        .rd_index (idx),
        .rd_valid (valid0),
        .rd_tag   (tag0),
        .rd_data  (data0)
    );

    cache_way_store #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .DATA_W  (DATA_W)
    ) u_way1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fill_en && victim_q),
        .wr_index (idx),
        .wr_tag   (tag),
        .wr_data  (mem_resp_data),
        .rd_index (idx),
        .rd_valid (valid1),
        .rd_tag   (tag1),
        .rd_data  (data1)
    );

    // Control FSM with registered outputs; strobes default low and are raised for one cycle.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            addr_q        <= '0;
            victim_q      <= 1'b0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_hit      <= 1'b0;
            resp_way      <= 1'b0;
            resp_data     <= '0;
            repl_update   <= 1'b0;
            mem_req_valid <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            repl_update <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        state     <= StLookup;
                    end
                end
                StLookup: begin
                    if (hit0 || hit1) begin
                        // Way0 wins if both ways somehow match.
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_way   <= !hit0;
                        resp_data  <= hit0 ? data0 : data1;
                        state      <= StResp;
                    end else begin
                        victim_q      <= pick_victim(valid0, valid1, repl_way);
                        mem_req_valid <= 1'b1;
                        state         <= StMissReq;
                    end
                end
                StMissReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= StMissWait;
                    end
                end
                StMissWait: begin
                    if (mem_resp_valid) begin
                        repl_update <= 1'b1;
                        state       <= StFill;
                    end
                end
                StFill: begin
                    // The way store already holds the new line, so read it back for the response.
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b0;
                    resp_way   <= victim_q;
                    resp_data  <= victim_q ? data1 : data0;
                    state      <= StResp;
                end
                StResp: begin
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    req_ready     <= 1'b1;
                    mem_req_valid <= 1'b0;
                    state         <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl; DUT acts on falling edges, outputs sampled 1 ns later.
module tb_cache_miss_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_way;
    logic [31:0] resp_data;
    logic [2:0]  repl_index;
    logic        repl_way;
    logic        repl_update;
    logic        mem_req_valid;
    logic [7:0]  mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int n_vec  = 0;
    int n_err  = 0;
    int n_repl = 0;
    int n_resp = 0;
    int n_mreq = 0;

    cache_miss_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way),
        .resp_data      (resp_data),
        .repl_index     (repl_index),
        .repl_way       (repl_way),
        .repl_update    (repl_update),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are stable between falling edges, so one rising-edge sample counts each cycle once.
    always @(posedge clk) begin
        if (repl_update)   n_repl++;
        if (resp_valid)    n_resp++;
        if (mem_req_valid) n_mreq++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Full miss: accept, request, handshake, response, fill, respond.
    task automatic run_miss(input logic [7:0] addr, input logic rway, input logic exp_way,
                            input logic [31:0] data);
        int r0;
        int s0;
        r0 = n_repl;
        s0 = n_resp;
        repl_way  = rway;
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check("miss_lookup_ready", req_ready, 1'b0);
        tick();
        check("miss_mreq_valid", mem_req_valid, 1'b1);
        check("miss_mreq_addr", mem_req_addr, addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("miss_mreq_drop", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        tick();
        mem_resp_valid = 1'b0;
        check("miss_repl_update", repl_update, 1'b1);
        check("miss_repl_index", repl_index, addr[2:0]);
        tick();
        check("miss_resp_valid", resp_valid, 1'b1);
        check("miss_resp_hit", resp_hit, 1'b0);
        check("miss_resp_way", resp_way, exp_way);
        check("miss_resp_data", resp_data, data);
        check("miss_repl_clear", repl_update, 1'b0);
        tick();
        check("miss_idle_ready", req_ready, 1'b1);
        check("miss_repl_pulses", n_repl - r0, 1);
        check("miss_resp_pulses", n_resp - s0, 1);
    endtask

    // Hit: response visible after the second falling edge counting the accepting one.
    task automatic run_hit(input logic [7:0] addr, input logic exp_way, input logic [31:0] data);
        int m0;
        m0 = n_mreq;
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        tick();
        check("hit_resp_valid", resp_valid, 1'b1);
        check("hit_resp_hit", resp_hit, 1'b1);
        check("hit_resp_way", resp_way, exp_way);
        check("hit_resp_data", resp_data, data);
        tick();
        check("hit_no_mreq", n_mreq - m0, 0);
        check("hit_idle_ready", req_ready, 1'b1);
    endtask

    initial begin
        int r0;
        int s0;
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = '0;
        repl_way       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        tick();
        reset = 1'b1;

        // 1: reset state, then first miss into empty set 3
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_mreq_valid", mem_req_valid, 1'b0);
        check("rst_repl_update", repl_update, 1'b0);
        check("rst_repl_index", repl_index, 3'd0);
        check("rst_resp_data", resp_data, 32'h0);
        run_miss(8'h23, 1'b1, 1'b0, 32'hA0A0_0023);

        // 2: same line now hits in way0; response held afterwards
        run_hit(8'h23, 1'b0, 32'hA0A0_0023);
        check("resp_data_held", resp_data, 32'hA0A0_0023);

        // 3: way1 still empty -> chosen despite repl_way=0; then full set follows repl_way
        run_miss(8'h43, 1'b0, 1'b1, 32'hB0B0_0043);
        run_miss(8'h63, 1'b0, 1'b0, 32'hC0C0_0063);
        run_hit(8'h43, 1'b1, 32'hB0B0_0043);
        run_hit(8'h63, 1'b0, 32'hC0C0_0063);

        // 4: stalled request, early response must be ignored
        r0 = n_repl;
        repl_way  = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h15;
        tick();
        req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_mreq_valid", mem_req_valid, 1'b1);
            check("stall_mreq_addr", mem_req_addr, 8'h15);
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        check("stall_no_early_fill", n_repl - r0, 0);
        check("stall_repl_low", repl_update, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1515_0015;
        tick();
        mem_resp_valid = 1'b0;
        check("stall_repl_update", repl_update, 1'b1);
        check("stall_repl_index", repl_index, 3'd5);
        tick();
        check("stall_resp_valid", resp_valid, 1'b1);
        check("stall_resp_way", resp_way, 1'b0);
        check("stall_resp_data", resp_data, 32'h1515_0015);
        tick();

        // 5: reset while waiting for memory abandons the miss
        req_valid = 1'b1;
        req_addr  = 8'h2A;
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        r0 = n_repl;
        s0 = n_resp;
        #2 reset = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_mreq_valid", mem_req_valid, 1'b0);
        check("arst_mreq_addr", mem_req_addr, 8'h00);
        check("arst_repl_index", repl_index, 3'd0);
        check("arst_resp_data", resp_data, 32'h0);
        check("arst_resp_way", resp_way, 1'b0);
        tick();
        reset          = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        tick();
        tick();
        mem_resp_valid = 1'b0;
        check("arst_no_repl", n_repl - r0, 0);
        check("arst_no_resp", n_resp - s0, 0);
        // All lines were invalidated: 0x63 misses and lands in way0 whatever repl_way says.
        run_miss(8'h63, 1'b1, 1'b0, 32'hC3C3_0063);

        // 6: request held through a miss is serviced exactly once
        s0 = n_resp;
        repl_way  = 1'b1;
        req_valid = 1'b1;
        req_addr  = 8'h2A;
        tick();
        tick();
        check("hold_ready_req", req_ready, 1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("hold_ready_wait", req_ready, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h2A2A_002A;
        tick();
        mem_resp_valid = 1'b0;
        check("hold_ready_fill", req_ready, 1'b0);
        tick();
        check("hold_resp_valid", resp_valid, 1'b1);
        check("hold_resp_way", resp_way, 1'b0);
        tick();
        req_valid = 1'b0;
        check("hold_idle_ready", req_ready, 1'b1);
        tick();
        tick();
        check("hold_one_resp", n_resp - s0, 1);
        run_hit(8'h2A, 1'b0, 32'h2A2A_002A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
